// File: rtl/demux_1_4_8_bit_v.sv
// Registered 1-to-4 demultiplexer with valid/ready handshakes.
// Each accepted input byte goes to one output channel, chosen either by an
// explicit select code or by a round-robin pointer. Each channel is a
// one-entry output register that can be drained and reloaded in the same
// cycle, so every channel sustains one byte per cycle.
//
// Handshake rule (input and every output channel): a transfer happens on a
// rising edge where valid and ready are both 1. The producer holds data and
// valid until that happens. o_ready never looks at i_valid.
module demux_1_4_8_bit_v #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic [1:0]       i_sel_code,
  input  logic             i_rr_mode,
  output logic [WIDTH-1:0] o_code_0,
  output logic [WIDTH-1:0] o_code_1,
  output logic [WIDTH-1:0] o_code_2,
  output logic [WIDTH-1:0] o_code_3,
  output logic [3:0]       o_valid,
  input  logic [3:0]       i_ready,
  output logic [1:0]       o_rr_ptr,
  output logic [CNT_W-1:0] o_xfer_cnt
);

  logic [WIDTH-1:0] data_q [4];
  logic [WIDTH-1:0] data_d [4];
  logic [3:0]       valid_q;
  logic [3:0]       valid_d;
  logic [1:0]       rr_ptr_q;
  logic [1:0]       rr_ptr_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic [1:0] tgt;
  logic       accept;

  // Target channel and input-side handshake.
  always_comb begin
    tgt     = i_rr_mode ? rr_ptr_q : i_sel_code;
    o_ready = i_en & (~valid_q[tgt] | i_ready[tgt]);
    accept  = i_valid & o_ready;
  end

  // Next state: load the target channel, drain the others, advance counters.
  always_comb begin
    data_d   = data_q;
    valid_d  = valid_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    for (int k = 0; k < 4; k++) begin
      if (accept && (tgt == 2'(k))) begin
        // A load wins over a drain on the same channel, keeping valid high.
        data_d[k]  = i_data;
        valid_d[k] = 1'b1;
      end else if (valid_q[k] && i_ready[k]) begin
        // Data register keeps its value; only the valid flag drops.
        valid_d[k] = 1'b0;
      end
    end
    if (accept) begin
      cnt_d = cnt_q + 1'b1;
      if (i_rr_mode) begin
        rr_ptr_d = rr_ptr_q + 2'd1;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
      end
      valid_q  <= 4'b0000;
      rr_ptr_q <= 2'd0;
      cnt_q    <= '0;
    end else begin
      data_q   <= data_d;
      valid_q  <= valid_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Output data is forced to zero on idle channels.
  always_comb begin
    o_code_0   = valid_q[0] ? data_q[0] : '0;
    o_code_1   = valid_q[1] ? data_q[1] : '0;
    o_code_2   = valid_q[2] ? data_q[2] : '0;
    o_code_3   = valid_q[3] ? data_q[3] : '0;
    o_valid    = valid_q;
    o_rr_ptr   = rr_ptr_q;
    o_xfer_cnt = cnt_q;
  end

endmodule
